// File: rtl/xoodyak_sequencer_pkg.sv
// Xoodyak sequencer shared encodings.
// Holds opmodes, FSM states and the default WAIT budget.
package xoodyak_sequencer_pkg;

   typedef enum logic [2:0] {
      OP_IDLE    = 3'd0,
      OP_INIT    = 3'd1,
      OP_NONCE   = 3'd2,
      OP_ASSOC   = 3'd3,
      OP_CRYPT   = 3'd4,
      OP_DECRYPT = 3'd5,
      OP_SQUEEZE = 3'd6,
      OP_RATCHET = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   localparam int TIMEOUT_DEF = 255;
   localparam int CNT_W       = 10;
   localparam int OP_W        = 4;

endpackage

// File: rtl/xoodyak_cmd_fifo.sv
// Command queue for the Xoodyak sequencer.
// Power-of-two depth; pointers wrap naturally, flush empties it.
module xoodyak_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   count;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign rdata = mem[rptr];

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/xoodyak_sequencer.sv
// Xoodyak command sequencer: queues host opmodes and
// launches them one at a time on the cipher core.
module xoodyak_sequencer
   import xoodyak_sequencer_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = TIMEOUT_DEF
) (
   input  logic            eph1,
   input  logic            reset,
   input  logic            cmd_valid,
   input  logic [OP_W-1:0] cmd_op,
   output logic            cmd_ready,
   output logic            start,
   output logic [OP_W-1:0] opmode,
   input  logic            finished,
   output logic            done,
   output logic [OP_W-1:0] done_op,
   output logic            busy,
   output logic            err_timeout,
   output logic            err_seq,
   input  logic            clr_err
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_e            state;
   logic [CNT_W-1:0]  wait_cnt;
   logic              init_seen;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic              flush;
   logic [OP_W-1:0]   head;
   logic              is_nop;
   logic              is_bad;
   logic              expire;

   assign cmd_ready = ~full;
   assign push      = cmd_valid & ~full;
   assign is_nop    = (head[2:0] == OP_IDLE);
   assign is_bad    = ~init_seen & (head[2:0] != OP_INIT);
   assign expire    = (state == S_WAIT) & ~finished
                    & (wait_cnt == CNT_LAST);
   assign flush     = expire;
   // Rejected heads leave straight from IDLE; issued ones on DONE.
   assign pop = ((state == S_IDLE) & ~empty & (is_nop | is_bad))
              | (state == S_DONE);

   xoodyak_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (OP_W)
   ) u_fifo (
      .clk   (eph1),
      .rst_n (reset),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .wdata (cmd_op),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge eph1 or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         wait_cnt    <= '0;
         init_seen   <= 1'b0;
         start       <= 1'b0;
         opmode      <= '0;
         done        <= 1'b0;
         done_op     <= '0;
         busy        <= 1'b0;
         err_timeout <= 1'b0;
         err_seq     <= 1'b0;
      end else begin
         start   <= 1'b0;
         done    <= 1'b0;
         done_op <= '0;
         if (clr_err) begin
            err_timeout <= 1'b0;
            err_seq     <= 1'b0;
         end
         unique case (state)
            S_IDLE: begin
               if (!empty && !is_nop) begin
                  if (is_bad) begin
                     err_seq <= 1'b1;
                  end else begin
                     state  <= S_ISSUE;
                     start  <= 1'b1;
                     opmode <= head;
                     busy   <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               state    <= S_WAIT;
               wait_cnt <= '0;
            end
            S_WAIT: begin
               if (finished) begin
                  state   <= S_DONE;
                  done    <= 1'b1;
                  done_op <= head;
                  opmode  <= '0;
               end else if (expire) begin
                  state       <= S_IDLE;
                  err_timeout <= 1'b1;
                  init_seen   <= 1'b0;
                  opmode      <= '0;
                  busy        <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               if (head[2:0] == OP_INIT) init_seen <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_xoodyak_sequencer.sv
// Directed and randomized bench for xoodyak_sequencer.
// Random phase uses a transaction-level queue model.
module tb_xoodyak_sequencer;

   logic       eph1;
   logic       reset;
   logic       cmd_valid;
   logic [3:0] cmd_op;
   logic       cmd_ready;
   logic       start;
   logic [3:0] opmode;
   logic       finished;
   logic       done;
   logic [3:0] done_op;
   logic       busy;
   logic       err_timeout;
   logic       err_seq;
   logic       clr_err;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [3:0] mq[$];
   bit         m_init;
   bit         m_err;
   logic [3:0] cur;

   xoodyak_sequencer #(
      .FIFO_DEPTH (4),
      .TIMEOUT    (8)
   ) dut (
      .eph1        (eph1),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_op      (cmd_op),
      .cmd_ready   (cmd_ready),
      .start       (start),
      .opmode      (opmode),
      .finished    (finished),
      .done        (done),
      .done_op     (done_op),
      .busy        (busy),
      .err_timeout (err_timeout),
      .err_seq     (err_seq),
      .clr_err     (clr_err)
   );

   initial begin
      eph1 = 1'b0;
      forever #5 eph1 = ~eph1;
   end

   task automatic tick();
      @(posedge eph1);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      cmd_valid = 1'b0;
      finished  = 1'b0;
      clr_err   = 1'b0;
      repeat (2) @(posedge eph1);
      #1;
      reset = 1'b1;
   endtask

   // Wait (bounded) for a launch, then complete it 5 cycles later.
   task automatic core_run(input logic [3:0] exp, input string tag);
      for (int i = 0; i < 12 && !start; i++) tick();
      chk({tag, "_start"}, start, 1);
      chk({tag, "_op"}, opmode, exp);
      repeat (5) tick();
      finished = 1'b1;
      tick();
      finished = 1'b0;
      chk({tag, "_done"}, done, 1);
      chk({tag, "_done_op"}, done_op, exp);
   endtask

   // Drop heads the sequencer must reject, as the rules dictate.
   task automatic model_skip();
      while (mq.size() > 0 &&
             (mq[0][2:0] == 3'd0 ||
              (!m_init && mq[0][2:0] != 3'd1))) begin
         if (mq[0][2:0] != 3'd0) m_err = 1'b1;
         void'(mq.pop_front());
      end
   endtask

   initial begin
      int         pn;
      int         cd;
      int         fin_cyc;
      bit         outst;
      logic [3:0] op;

      reset     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      finished  = 1'b0;
      clr_err   = 1'b0;

      #12;
      chk("rst_start", start, 0);
      chk("rst_opmode", opmode, 0);
      chk("rst_done", done, 0);
      chk("rst_done_op", done_op, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err_to", err_timeout, 0);
      chk("rst_err_seq", err_seq, 0);
      @(posedge eph1);
      #1;
      reset = 1'b1;
      chk("rst_ready", cmd_ready, 1);

      // Non-initialize op first: dropped with err_seq.
      cmd_valid = 1'b1;
      cmd_op    = 4'd4;
      tick();
      cmd_valid = 1'b0;
      tick();
      chk("seq_err", err_seq, 1);
      chk("seq_nostart", start, 0);
      tick();
      chk("seq_nostart2", start, 0);
      chk("seq_busy", busy, 0);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("seq_clr", err_seq, 0);

      // Opmode 0 (with continue bit) is silently consumed.
      cmd_valid = 1'b1;
      cmd_op    = 4'h8;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("nop_busy", busy, 0);
         chk("nop_start", start, 0);
         chk("nop_done", done, 0);
         chk("nop_err", err_seq, 0);
      end

      // Two commands, latency and ISSUE-cycle finished.
      cmd_valid = 1'b1;
      cmd_op    = 4'd1;
      tick();
      cmd_op = 4'd2;
      chk("lat_pre", start, 0);
      tick();
      cmd_valid = 1'b0;
      chk("lat_start", start, 1);
      chk("lat_op", opmode, 1);
      finished = 1'b1;
      tick();
      finished = 1'b0;
      chk("iss_fin_done", done, 0);
      chk("wait_busy", busy, 1);
      chk("wait_op", opmode, 1);
      repeat (3) tick();
      tick();
      finished = 1'b1;
      tick();
      finished = 1'b0;
      chk("op1_done", done, 1);
      chk("op1_done_op", done_op, 1);
      chk("done_opmode0", opmode, 0);
      core_run(4'd2, "op2");

      // Five back-to-back pushes against a depth-4 queue.
      cmd_valid = 1'b1;
      cmd_op    = 4'hB;
      tick();
      cmd_op = 4'd4;
      tick();
      cmd_op = 4'd5;
      chk("full_start", start, 1);
      chk("full_op", opmode, 4'hB);
      tick();
      cmd_op = 4'd6;
      chk("full_rdy3", cmd_ready, 1);
      tick();
      cmd_op = 4'd7;
      chk("full_rdy4", cmd_ready, 0);
      tick();
      chk("full_rdy5", cmd_ready, 0);
      tick();
      tick();
      finished = 1'b1;
      tick();
      finished = 1'b0;
      chk("full_done", done, 1);
      chk("full_done_op", done_op, 4'hB);
      chk("full_rdy_d", cmd_ready, 0);
      tick();
      chk("full_rdy_free", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      core_run(4'd4, "q4");
      core_run(4'd5, "q5");
      core_run(4'd6, "q6");
      core_run(4'd7, "q7");

      // Timeout after 8 WAIT cycles flushes the queue.
      cmd_valid = 1'b1;
      cmd_op    = 4'd1;
      tick();
      cmd_op = 4'd3;
      tick();
      cmd_op = 4'd5;
      chk("to_start", start, 1);
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("to_nodone", done, 0);
      end
      chk("to_edge", err_timeout, 0);
      chk("to_edge_busy", busy, 1);
      tick();
      chk("to_flag", err_timeout, 1);
      chk("to_busy", busy, 0);
      chk("to_done", done, 0);
      chk("to_opmode", opmode, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("flush_start", start, 0);
         chk("flush_err", err_seq, 0);
      end

      // Init-seen cleared; clr_err against a new error.
      cmd_valid = 1'b1;
      cmd_op    = 4'd5;
      tick();
      cmd_valid = 1'b0;
      clr_err   = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("set_wins", err_seq, 1);
      chk("clr_to", err_timeout, 0);

      // Asynchronous reset while WAITing.
      cmd_valid = 1'b1;
      cmd_op    = 4'd1;
      tick();
      cmd_valid = 1'b0;
      tick();
      chk("ar_start", start, 1);
      tick();
      tick();
      chk("ar_busy", busy, 1);
      chk("ar_op", opmode, 1);
      #2;
      reset = 1'b0;
      #1;
      chk("ar_start0", start, 0);
      chk("ar_opmode0", opmode, 0);
      chk("ar_busy0", busy, 0);
      chk("ar_done0", done, 0);
      chk("ar_done_op0", done_op, 0);
      chk("ar_err_seq0", err_seq, 0);
      chk("ar_err_to0", err_timeout, 0);
      @(posedge eph1);
      @(posedge eph1);
      #1;
      reset = 1'b1;
      chk("ar_ready", cmd_ready, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ar_nodone", done, 0);
      end
      cmd_valid = 1'b1;
      cmd_op    = 4'd1;
      tick();
      cmd_valid = 1'b0;
      core_run(4'd1, "post_rst");

      // Randomized batches against the queue model.
      do_reset();
      m_init  = 1'b0;
      fin_cyc = -10;
      for (int b = 0; b < 16; b++) begin
         clr_err = 1'b1;
         tick();
         clr_err = 1'b0;
         m_err   = 1'b0;
         pn      = $urandom_range(1, 6);
         cd      = 0;
         outst   = 1'b0;
         for (int c = 0; c < 100; c++) begin
            finished = 1'b0;
            if (cd > 0) begin
               cd--;
               if (cd == 0) begin
                  finished = 1'b1;
                  fin_cyc  = cyc;
               end
            end else if (!outst && $urandom_range(0, 3) == 0) begin
               finished = 1'b1;
            end
            if (done) begin
               chk("rnd_done_exp", outst, 1);
               chk("rnd_done_op", done_op, cur);
               chk("rnd_done_lat", cyc, fin_cyc + 1);
               if (cur[2:0] == 3'd1) m_init = 1'b1;
               outst = 1'b0;
            end
            if (start) begin
               model_skip();
               chk("rnd_start_exp", mq.size() > 0, 1);
               cur = 4'bx;
               if (mq.size() > 0) cur = mq.pop_front();
               chk("rnd_start_op", opmode, cur);
               outst    = 1'b1;
               cd       = $urandom_range(1, 5);
               finished = 1'($urandom_range(0, 1));
            end
            cmd_valid = 1'b0;
            if (pn > 0 && cmd_ready) begin
               op        = 4'($urandom_range(0, 15));
               cmd_valid = 1'b1;
               cmd_op    = op;
               mq.push_back(op);
               pn--;
            end
            tick();
         end
         finished  = 1'b0;
         cmd_valid = 1'b0;
         model_skip();
         chk("rnd_drain", mq.size(), 0);
         chk("rnd_outst", outst, 0);
         chk("rnd_err_seq", err_seq, m_err);
         chk("rnd_idle", busy, 0);
         chk("rnd_err_to", err_timeout, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/xoodyak_sequencer.md
XOODYAK_SEQUENCER -- requirements
Module: xoodyak_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, command queue depth; SHALL be a power of 2 and at least 2.
REQ-002 Parameter TIMEOUT, default 255, maximum WAIT cycles before abort; range 1..1023.
REQ-003 eph1  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  upstream command offered.
REQ-006 cmd_op  in  4  opmode: 0 idle, 1 initialize, 2 nonce, 3 assoc, 4 crypt, 5 decrypt, 6 squeeze, 7 ratchet; bit3 is the continue flag.
REQ-007 cmd_ready  out  1  queue can accept a command.
REQ-008 start  out  1  one-cycle launch pulse to the cipher core.
REQ-009 opmode  out  4  opmode presented to the cipher core.
REQ-010 finished  in  1  core completion strobe.
REQ-011 done  out  1  one-cycle completion pulse to the host.
REQ-012 done_op  out  4  opmode of the completed command; valid while done=1.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 err_timeout  out  1  sticky timeout flag.
REQ-015 err_seq  out  1  sticky sequencing-violation flag.
REQ-016 clr_err  in  1  synchronous clear of both error flags.

Function
REQ-017 Queue: push on cmd_valid & cmd_ready. cmd_ready SHALL be ~full, computed from the registered count with no same-cycle bypass.
REQ-018 State machine SHALL have states IDLE, ISSUE, WAIT and DONE.
REQ-019 IDLE with a non-empty queue SHALL classify the head: op[2:0]==0 is popped silently with no start; a non-initialize op before any completed initialize since reset is popped and sets err_seq; any other op SHALL go to ISSUE.
REQ-020 ISSUE SHALL last exactly one cycle with start=1 and opmode=head, then go to WAIT with the wait counter cleared.
REQ-021 WAIT SHALL hold opmode=head and increment the counter each cycle; finished=1 SHALL go to DONE.
REQ-022 finished asserted during ISSUE or IDLE SHALL be ignored.
REQ-023 DONE SHALL last one cycle: done=1, done_op=head, pop the head, set the init-seen flag if head[2:0]==1, then return to IDLE.
REQ-024 Latency: a command accepted in cycle N on an idle, empty block SHALL produce start in cycle N+2; finished in cycle M SHALL produce done in cycle M+1.
REQ-025 If the WAIT counter reaches TIMEOUT without finished, the block SHALL set err_timeout, flush the queue, clear init-seen and enter IDLE with no done.
REQ-026 opmode SHALL be 0 in IDLE and DONE.
REQ-027 Push and pop in the same cycle SHALL leave the count unchanged; queue pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 clr_err coincident with a new error SHALL leave the flag set (set wins).

Reset
REQ-029 On reset=0: state IDLE; queue empty; init-seen=0; counter 0; start=0, opmode=0, done=0, done_op=0, busy=0, err_timeout=0, err_seq=0. cmd_ready SHALL be 1 from the first cycle after release.
REQ-030 Reset asserted mid-operation SHALL abort immediately with no done pulse.

Structure
REQ-031 A shared package SHALL hold the opmode enum (the values in REQ-006), the state enum and the default TIMEOUT.
REQ-032 The queue SHALL be a separate sub-module, xoodyak_cmd_fifo; sequencing logic stays in the top module.

Verification
REQ-033 Push op 1 then op 2; finished returns 5 cycles after each start -> two start pulses with opmode 1 and 2, and done_op sequence 1, 2.
REQ-034 After reset, push op 4 first -> no start, err_seq=1, entry dropped; then clr_err -> err_seq=0.
REQ-035 Push 5 commands back-to-back while the core is stalled -> cmd_ready=0 after the 4th accept and the 5th is held, not lost.
REQ-036 TIMEOUT=8, push op 1, never assert finished -> err_timeout=1 after 8 WAIT cycles, queue empty, no done.
REQ-037 Assert reset during WAIT -> all outputs return to reset values asynchronously; the next op 1 runs normally.
REQ-038 Push op 0 -> popped with no start and no done; busy stays 0.
